// File: rtl/fnd_pkg.sv
// Shared constants, types and helpers for the 4-digit time display.
// Latency: n/a (package only).
// Backpressure: n/a.
package fnd_pkg;

  localparam int NUM_DIGITS      = 4;
  localparam int BCD_CONV_CYCLES = 8;

  // Active-low {g,f,e,d,c,b,a} patterns for a common-anode display.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_e;

  // Two digits can show at most 99, so larger inputs saturate.
  function automatic logic [7:0] clamp99(input logic [7:0] v);
    return (v > 8'd99) ? 8'd99 : v;
  endfunction

  // Add-3 step of the shift-add-3 (double dabble) algorithm.
  function automatic logic [7:0] bcd_adjust(input logic [7:0] a);
    logic [3:0] t;
    logic [3:0] o;
    t = a[7:4];
    o = a[3:0];
    if (t >= 4'd5) t = t + 4'd3;
    if (o >= 4'd5) o = o + 4'd3;
    return {t, o};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential 8-bit binary (0..99) to two-digit BCD converter, shift-add-3.
// Latency: start accepted in IDLE, 8 SHIFT cycles, done pulses for one cycle in DONE.
// Backpressure: start is ignored while busy; caller must hold its request until idle.
// Ports: clk, reset_p (sync, active-low), start, bin[7:0] -> busy, done, bcd[7:0] {tens,ones}.
module bin_to_bcd_seq
  import fnd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_p,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [7:0] bcd
);

  conv_state_e state_q, state_d;
  logic [7:0]  sh_q, sh_d;    // binary operand, consumed MSB first
  logic [7:0]  acc_q, acc_d;  // BCD accumulator {tens, ones}
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  adj;

  assign adj = bcd_adjust(acc_q);

  always_ff @(posedge clk) begin
    if (!reset_p) begin
      state_q <= CONV_IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      CONV_IDLE: begin
        if (start) begin
          sh_d    = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        // Tens never exceeds 4 before the final shift for inputs <= 99,
        // so dropping adj[7] loses nothing.
        acc_d = {adj[6:0], sh_q[7]};
        sh_d  = {sh_q[6:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(BCD_CONV_CYCLES - 1)) state_d = CONV_DONE;
      end
      CONV_DONE: state_d = CONV_IDLE;
      default:   state_d = CONV_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != CONV_IDLE);
    done = (state_q == CONV_DONE);
    bcd  = acc_q;
  end

endmodule

// File: rtl/fnd_time_display.sv
// Minutes:seconds to BCD plus 4-digit multiplexed common-anode 7-segment drive with colon and blink.
// Latency: bcd valid 10 edges after a stable input change; com/seg_7 registered together.
// Backpressure: none; input changes during a conversion are picked up at the next idle compare.
// Ports: clk, reset_p (sync, active-low), value_hi/value_lo[7:0], blink_en, dp_en
//        -> bcd[15:0] {hi_tens,hi_ones,lo_tens,lo_ones}, com[3:0] (active-low), seg_7[7:0] {dp,g..a} (active-low).
module fnd_time_display
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [7:0]  value_hi,
  input  logic [7:0]  value_lo,
  input  logic        blink_en,
  input  logic        dp_en,
  output logic [15:0] bcd,
  output logic [3:0]  com,
  output logic [7:0]  seg_7
);

  localparam int SW    = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // ---------------- conversion control ----------------
  logic [7:0]  hi_c, lo_c;
  logic [15:0] snap_q, snap_d;
  logic        force_q, force_d;
  logic        conv_start, conv_busy, conv_done;
  logic        hi_busy, hi_done, lo_busy, lo_done;
  logic [7:0]  hi_bcd, lo_bcd;
  logic [15:0] bcd_q, bcd_d;

  assign hi_c = clamp99(value_hi);
  assign lo_c = clamp99(value_lo);

  // Comparing the clamped value keeps an out-of-range input from
  // retriggering a conversion forever.
  assign conv_busy  = hi_busy | lo_busy;
  assign conv_done  = hi_done & lo_done;
  assign conv_start = !conv_busy && (force_q || ({hi_c, lo_c} != snap_q));

  always_comb begin
    snap_d  = snap_q;
    force_d = force_q;
    bcd_d   = bcd_q;
    if (conv_start) begin
      snap_d  = {hi_c, lo_c};
      force_d = 1'b0;
    end
    if (conv_done) bcd_d = {hi_bcd, lo_bcd};
  end

  bin_to_bcd_seq u_conv_hi (
    .clk     (clk),
    .reset_p (reset_p),
    .start   (conv_start),
    .bin     (hi_c),
    .busy    (hi_busy),
    .done    (hi_done),
    .bcd     (hi_bcd)
  );

  bin_to_bcd_seq u_conv_lo (
    .clk     (clk),
    .reset_p (reset_p),
    .start   (conv_start),
    .bin     (lo_c),
    .busy    (lo_busy),
    .done    (lo_done),
    .bcd     (lo_bcd)
  );

  // ---------------- scan and blink ----------------
  logic [SW-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BW-1:0]    blk_q, blk_d;
  logic             phase_q, phase_d;
  logic [3:0]       com_q, com_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       nib;

  always_comb begin
    pre_d   = (pre_q == SCAN_LAST) ? '0 : pre_q + SW'(1);
    idx_d   = (pre_q == SCAN_LAST) ? idx_q + IDX_W'(1) : idx_q;
    blk_d   = (blk_q == BLINK_LAST) ? '0 : blk_q + BW'(1);
    phase_d = (blk_q == BLINK_LAST) ? ~phase_q : phase_q;
  end

  // Segments are built from next-state index/bcd/phase so they land on
  // the same edge as com and never show a neighbouring digit.
  always_comb begin
    nib = 4'd0;
    case (idx_d)
      2'd0: nib = bcd_d[3:0];
      2'd1: nib = bcd_d[7:4];
      2'd2: nib = bcd_d[11:8];
      2'd3: nib = bcd_d[15:12];
      default: nib = 4'd0;
    endcase
    com_d = ~(4'b0001 << idx_d);
    if (blink_en && !phase_d) begin
      seg_d = 8'hFF;
    end else begin
      seg_d = {~((idx_d == IDX_W'(2)) && dp_en && phase_d), seg_decode(nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_p) begin
      snap_q  <= '0;
      force_q <= 1'b1;
      bcd_q   <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b1;
      com_q   <= 4'b1110;
      seg_q   <= 8'b1100_0000;
    end else begin
      snap_q  <= snap_d;
      force_q <= force_d;
      bcd_q   <= bcd_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      com_q   <= com_d;
      seg_q   <= seg_d;
    end
  end

  assign bcd   = bcd_q;
  assign com   = com_q;
  assign seg_7 = seg_q;

endmodule

// File: tb/tb_fnd_time_display.sv
module tb_fnd_time_display;

  localparam int SCAN  = 4;
  localparam int BLINK = 16;

  logic        clk = 1'b0;
  logic        reset_p;
  logic [7:0]  value_hi, value_lo;
  logic        blink_en, dp_en;
  logic [15:0] bcd;
  logic [3:0]  com;
  logic [7:0]  seg_7;

  int errors = 0;
  int checks = 0;

  fnd_time_display #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
    .clk      (clk),
    .reset_p  (reset_p),
    .value_hi (value_hi),
    .value_lo (value_lo),
    .blink_en (blink_en),
    .dp_en    (dp_en),
    .bcd      (bcd),
    .com      (com),
    .seg_7    (seg_7)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [15:0] bcd_of(input int hi, input int lo);
    int h, l;
    h = (hi > 99) ? 99 : hi;
    l = (lo > 99) ? 99 : lo;
    return {4'(h / 10), 4'(h % 10), 4'(l / 10), 4'(l % 10)};
  endfunction

  int          m_cyc;        // edges since the reset edge
  int          m_busy;       // edges left until the running conversion lands
  bit          m_force;
  int          m_snap_hi, m_snap_lo;
  logic [15:0] m_bcd;
  logic [15:0] exp_bcd;
  logic [3:0]  exp_com;
  logic [7:0]  exp_seg;
  bit          model_vld = 0;

  always @(posedge clk) begin
    int idx, ph, chi, clo, nib;
    chi = (value_hi > 99) ? 99 : int'(value_hi);
    clo = (value_lo > 99) ? 99 : int'(value_lo);
    if (!reset_p) begin
      m_cyc = 0; m_busy = 0; m_force = 1;
      m_snap_hi = 0; m_snap_lo = 0; m_bcd = 16'h0000;
    end else begin
      // Conversions take ten edges: start edge plus nine until bcd lands.
      if (m_busy == 0) begin
        if (m_force || chi != m_snap_hi || clo != m_snap_lo) begin
          m_snap_hi = chi; m_snap_lo = clo; m_force = 0; m_busy = 9;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) m_bcd = bcd_of(m_snap_hi, m_snap_lo);
      end
      m_cyc++;
    end
    idx = (m_cyc / SCAN) % 4;
    ph  = 1 - ((m_cyc / BLINK) % 2);
    nib = int'(m_bcd[4*idx +: 4]);
    exp_bcd = m_bcd;
    exp_com = 4'b1111 ^ (4'b0001 << idx);
    if (blink_en && ph == 0) exp_seg = 8'hFF;
    else exp_seg = {~(idx == 2 && dp_en && ph == 1), seg_of(nib)};
    model_vld = 1;
  end

  // One compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_vld) begin
      checks += 3;
      if (bcd !== exp_bcd) begin
        errors++;
        $display("FAIL model_bcd t=%0t got=%h exp=%h", $time, bcd, exp_bcd);
      end
      if (com !== exp_com) begin
        errors++;
        $display("FAIL model_com t=%0t got=%b exp=%b", $time, com, exp_com);
      end
      if (seg_7 !== exp_seg) begin
        errors++;
        $display("FAIL model_seg t=%0t got=%b exp=%b", $time, seg_7, exp_seg);
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] scan_seg_5907(input logic [3:0] c);
    case (c)
      4'b1110: return 8'hF8;  // 7
      4'b1101: return 8'hC0;  // 0
      4'b1011: return 8'h90;  // 9
      4'b0111: return 8'h92;  // 5
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    int cnt;
    bit saw_mid, saw_final;
    reset_p = 0; value_hi = 0; value_lo = 0; blink_en = 0; dp_en = 0;
    tick(3);
    check("reset_com", {12'h0, com}, 16'h000E);
    check("reset_seg", {8'h0, seg_7}, 16'h00C0);
    check("reset_bcd", bcd, 16'h0000);
    reset_p = 1;
    tick(10);
    check("first_conv_bcd", bcd, 16'h0000);
    tick(5);

    value_hi = 59; value_lo = 7;
    tick(9);
    check("5907_not_early", bcd, 16'h0000);
    tick(1);
    check("5907_at_10", bcd, 16'h5907);

    for (int i = 0; i < 16; i++) begin
      tick(1);
      check("scan_seg", {8'h0, seg_7}, {8'h0, scan_seg_5907(com)});
    end

    // Step value_lo during an in-flight SHIFT.
    value_lo = 6;
    tick(15);
    value_lo = 7;
    tick(3);
    value_lo = 8;
    saw_mid = 0; saw_final = 0;
    for (int i = 0; i < 20 && !saw_final; i++) begin
      tick(1);
      if (bcd == 16'h5907) saw_mid = 1;
      if (bcd == 16'h5908) saw_final = 1;
    end
    check("mid_shift_intermediate", {15'h0, saw_mid}, 16'h0001);
    check("mid_shift_final_in_20", {15'h0, saw_final}, 16'h0001);

    value_hi = 200; value_lo = 150;
    tick(12);
    check("clamp_9999", bcd, 16'h9999);
    tick(12);
    check("clamp_stable", bcd, 16'h9999);

    dp_en = 1;
    tick(1);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      tick(1);
      if (seg_7[7] == 1'b0) cnt++;
    end
    check("dp_count_64", 16'(cnt), 16'd8);

    dp_en = 0; blink_en = 1;
    tick(1);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      tick(1);
      if (seg_7 == 8'hFF) cnt++;
    end
    check("blank_count_64", 16'(cnt), 16'd32);

    reset_p = 0;
    tick(1);
    check("midblink_reset_bcd", bcd, 16'h0000);
    check("midblink_reset_seg", {8'h0, seg_7}, 16'h00C0);
    check("midblink_reset_com", {12'h0, com}, 16'h000E);
    tick(2);
    reset_p = 1;

    for (int i = 0; i < 500; i++) begin
      tick(1);
      if ($urandom_range(0, 7) == 0) value_hi = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) value_lo = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) dp_en = ~dp_en;
      if ($urandom_range(0, 15) == 0) blink_en = ~blink_en;
      reset_p = ($urandom_range(0, 149) != 0);
    end
    reset_p = 1;
    value_hi = 42; value_lo = 13;
    tick(25);
    check("final_bcd", bcd, 16'h4213);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
